// File: rtl/turing_tape.sv
// turing_tape: parametrised TM tape with a valid/ready op port, clamp or wrap head and a multi-cycle CLEAR sweep
module turing_tape #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int WRAP = 0,
  parameter int HOME = 0,
  parameter logic [SYM_W-1:0] BLANK = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_write,
  input  logic [1:0]        op_move,
  input  logic [SYM_W-1:0]  wr_sym,
  output logic [SYM_W-1:0]  rd_sym,
  output logic              rd_valid,
  output logic [SYM_W-1:0]  cur_sym,
  output logic [ADDR_W-1:0] head,
  output logic              at_min,
  output logic              at_max,
  output logic              oob,
  output logic              busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] HOME_A = ADDR_W'(HOME);
  logic [SYM_W-1:0] cells [DEPTH];
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] head_nxt;
  logic accept, left, right, bump;
  assign op_ready = state == IDLE && !clear_req;
  assign accept = op_valid && op_ready;
  assign left = op_move == 2'b01;
  assign right = op_move == 2'b10;
  assign at_min = head == '0;
  assign at_max = head == LAST;
  assign busy = state == CLEAR;
  assign cur_sym = cells[head];
  // bump: a move that would leave the tape; it wraps or holds depending on WRAP
  assign bump = (left && at_max) || (right && at_min);
  always_comb
    head_nxt = left  ? (at_max ? (WRAP != 0 ? '0 : head) : head + ADDR_W'(1)) :
               right ? (at_min ? (WRAP != 0 ? LAST : head) : head - ADDR_W'(1)) : head;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= BLANK;
      head <= HOME_A;
      state <= IDLE;
      cnt <= '0;
      rd_sym <= BLANK;
      rd_valid <= 1'b0;
      oob <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (state == IDLE) begin
        if (clear_req) begin
          state <= CLEAR;
          cnt <= '0;
          oob <= 1'b0;
        end else if (op_valid) begin
          rd_sym <= cells[head];
          if (op_write) cells[head] <= wr_sym;
          head <= head_nxt;
          if (WRAP == 0 && bump) oob <= 1'b1;
        end
      end else begin
        cells[cnt] <= BLANK;
        cnt <= cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          head <= HOME_A;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_turing_tape.sv
// tb_turing_tape: clamp and wrap tapes driven in lockstep, checked against an array model and a read scoreboard
module tb_turing_tape;
  localparam int D = 16;
  typedef struct { logic [1:0] s; int c; } exp_t;
  logic clk = 0, reset = 1, clear_req = 0, op_valid = 0, op_write = 0;
  logic [1:0] op_move = 0, wr_sym = 0;
  logic op_ready [2], rd_valid [2], at_min [2], at_max [2], oob [2], busy [2];
  logic [1:0] rd_sym [2], cur_sym [2];
  logic [3:0] head [2];
  int checks = 0, errors = 0, cyc = 0;
  int mt [2][D];
  int mh [2];
  bit mo [2];
  exp_t q0 [$], q1 [$];

  turing_tape #(.WRAP(0)) u0 (.clk(clk), .reset(reset), .clear_req(clear_req), .op_valid(op_valid),
    .op_ready(op_ready[0]), .op_write(op_write), .op_move(op_move), .wr_sym(wr_sym), .rd_sym(rd_sym[0]),
    .rd_valid(rd_valid[0]), .cur_sym(cur_sym[0]), .head(head[0]), .at_min(at_min[0]), .at_max(at_max[0]),
    .oob(oob[0]), .busy(busy[0]));
  turing_tape #(.WRAP(1)) u1 (.clk(clk), .reset(reset), .clear_req(clear_req), .op_valid(op_valid),
    .op_ready(op_ready[1]), .op_write(op_write), .op_move(op_move), .wr_sym(wr_sym), .rd_sym(rd_sym[1]),
    .rd_valid(rd_valid[1]), .cur_sym(cur_sym[1]), .head(head[1]), .at_min(at_min[1]), .at_max(at_max[1]),
    .oob(oob[1]), .busy(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid[0]) begin
      if (q0.size() == 0) chk("rd_valid0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("rd_sym0", rd_sym[0], e.s);
        chk("rd_lat0", cyc, e.c);
      end
    end
    if (rd_valid[1]) begin
      if (q1.size() == 0) chk("rd_valid1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rd_sym1", rd_sym[1], e.s);
        chk("rd_lat1", cyc, e.c);
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < D; i++) mt[d][i] = 3;
      mh[d] = 0;
      mo[d] = 0;
    end
  endtask

  task automatic op(bit w, logic [1:0] mv, logic [1:0] s);
    @(negedge clk);
    op_valid = 1; op_write = w; op_move = mv; wr_sym = s;
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.s = 2'(mt[d][mh[d]]);
      e.c = cyc + 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (w) mt[d][mh[d]] = int'(s);
      if (mv == 2'b01) begin
        if (mh[d] < D - 1) mh[d]++;
        else if (d == 1) mh[d] = 0;
        else mo[d] = 1;
      end else if (mv == 2'b10) begin
        if (mh[d] > 0) mh[d]--;
        else if (d == 1) mh[d] = D - 1;
        else mo[d] = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    op_valid = 0; clear_req = 0;
  endtask

  task automatic check_state();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("head%0d", d), head[d], mh[d]);
      chk($sformatf("at_min%0d", d), at_min[d], mh[d] == 0);
      chk($sformatf("at_max%0d", d), at_max[d], mh[d] == D - 1);
      chk($sformatf("oob%0d", d), oob[d], mo[d]);
      chk($sformatf("busy%0d", d), busy[d], 0);
      chk($sformatf("op_ready%0d", d), op_ready[d], 1);
      chk($sformatf("cur_sym%0d", d), cur_sym[d], mt[d][mh[d]]);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) op(0, 2'b01, 0);
    idle();
    check_state();
  endtask

  // rst_at > 0 pulses reset at that CLEAR cycle (counted from 1) instead of letting the sweep finish
  task automatic do_clear(bit with_op, int rst_at);
    int n = 0;
    @(negedge clk);
    clear_req = 1; op_valid = with_op; op_write = 1; op_move = 2'b01; wr_sym = 0;
    #1;
    chk("ready0_on_clear_req", op_ready[0], 0);
    chk("ready1_on_clear_req", op_ready[1], 0);
    @(negedge clk);
    clear_req = 0; op_valid = 1'($urandom_range(0, 1));
    for (int i = 0; i < 24; i++) begin
      if (busy[0]) begin
        n++;
        chk("ready_in_clear", op_ready[0], 0);
        chk("busy_match", busy[1], 1);
      end
      if (rst_at > 0 && n == rst_at) begin
        reset = 1; op_valid = 0; clear_req = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
        check_state();
        return;
      end
      op_valid = busy[0] ? 1'($urandom_range(0, 1)) : 1'b0;
      clear_req = busy[0] ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    chk("clear_cycles", n, D);
    model_reset();
    check_state();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check_state();
    op(0, 2'b00, 0);
    idle();
    check_state();
    repeat (3) op(1, 2'b01, 2'b01);
    repeat (3) op(0, 2'b10, 0);
    idle();
    check_state();
    repeat (15) op(0, 2'b01, 0);
    idle();
    check_state();
    op(0, 2'b01, 0);
    idle();
    check_state();
    op(0, 2'b10, 0);
    idle();
    check_state();
    repeat (17) op(1, 2'b10, 2'b00);
    repeat (17) op(1, 2'b01, 2'b00);
    idle();
    check_state();
    do_clear(0, 0);
    read_all();
    do_clear(1, 0);
    for (int i = 0; i < 40; i++) op(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
    do_clear(0, 6);
    read_all();
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) do_clear(1'($urandom_range(0, 1)), 0);
      else if (r == 1) idle();
      else op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    idle();
    check_state();
    repeat (2) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
